// File: rtl/dma_ctrl.sv
// dma_ctrl: block-copy DMA engine that shares one memory port with a CPU.
// A CPU write to REG_ADDR latches the source page and copies LEN bytes from
// {src,idx} to DST_BASE+idx, one READ/WRITE pair per byte. The CPU is locked
// out of memory for the whole transfer.
module dma_ctrl #(
  parameter int unsigned LEN      = 160,
  parameter logic [15:0] DST_BASE = 16'hFE00,
  parameter logic [15:0] REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_write,
  input  logic        cpu_do_write,
  output logic [7:0]  cpu_data_read,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_write,
  output logic        mem_do_write,
  input  logic [7:0]  mem_data_read,
  output logic        dma_active
);

  localparam int unsigned IDX_W = 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       src;
  logic [IDX_W-1:0] idx;
  logic [7:0]       data_buf;
  logic             reg_hit;
  logic             reg_wr;

  assign reg_hit = (cpu_addr == REG_ADDR);
  assign reg_wr  = cpu_do_write && reg_hit;

  // State, source page, byte index and data buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src      <= 8'h00;
      idx      <= '0;
      data_buf <= 8'h00;
    end else begin
      state <= state_next;
      if (reg_wr) begin
        src <= cpu_data_write;
        idx <= '0;
      end else if (state == WRITE && idx != IDX_LAST) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == READ) begin
        data_buf <= mem_data_read;
      end
    end
  end

  // Next state: a start-register write restarts from any state
  always_comb begin
    state_next = state;
    if (reg_wr) begin
      state_next = START;
    end else begin
      unique case (state)
        IDLE:    state_next = IDLE;
        START:   state_next = READ;
        READ:    state_next = WRITE;
        WRITE:   state_next = (idx == IDX_LAST) ? IDLE : READ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Port arbitration: CPU owns memory in IDLE, DMA owns it otherwise
  always_comb begin
    dma_active     = (state != IDLE);
    cpu_data_read  = 8'hFF;
    mem_addr       = {src, 8'h00};
    mem_data_write = data_buf;
    mem_do_write   = 1'b0;
    unique case (state)
      IDLE: begin
        mem_addr       = cpu_addr;
        mem_data_write = cpu_data_write;
        mem_do_write   = cpu_do_write && !reg_hit;
        cpu_data_read  = mem_data_read;
      end
      START: begin
        mem_addr = {src, 8'h00};
      end
      READ: begin
        mem_addr = {src, idx};
      end
      WRITE: begin
        mem_addr       = DST_BASE + {8'h00, idx};
        mem_data_write = data_buf;
        mem_do_write   = 1'b1;
      end
      default: begin
        mem_addr = {src, 8'h00};
      end
    endcase
    if (reg_hit) begin
      cpu_data_read = src;
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a behavioural memory and scoreboards for
// CPU reads and memory writes.
module tb_dma_ctrl;

  localparam int unsigned LEN = 160;
  localparam logic [15:0] DST = 16'hFE00;
  localparam logic [15:0] REG = 16'hFF46;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_write;
  logic        cpu_do_write;
  logic [7:0]  cpu_data_read;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_write;
  logic        mem_do_write;
  logic [7:0]  mem_data_read;
  logic        dma_active;

  logic [7:0] mem [0:65535];
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  wr_t        exp_w;
  int         n_cmp;
  int         n_err;
  int         act_cnt;
  int         a0;
  bit         c010_ab;

  dma_ctrl #(.LEN(LEN), .DST_BASE(DST), .REG_ADDR(REG)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_addr       (cpu_addr),
    .cpu_data_write (cpu_data_write),
    .cpu_do_write   (cpu_do_write),
    .cpu_data_read  (cpu_data_read),
    .mem_addr       (mem_addr),
    .mem_data_write (mem_data_write),
    .mem_do_write   (mem_do_write),
    .mem_data_read  (mem_data_read),
    .dma_active     (dma_active)
  );

  assign mem_data_read = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model plus write scoreboard and dma_active cycle counter
  always @(posedge clk) begin
    if (dma_active === 1'b1) act_cnt++;
    if (mem_do_write === 1'b1) begin
      mem[mem_addr] <= mem_data_write;
      n_cmp++;
      if (wr_q.size() == 0) begin
        assert (1'b0) else begin
          n_err++;
          $error("FAIL mem_write_unexpected observed=%h:%h expected=none", mem_addr, mem_data_write);
        end
      end else begin
        exp_w = wr_q.pop_front();
        assert ({mem_addr, mem_data_write} === exp_w) else begin
          n_err++;
          $error("FAIL mem_write observed=%h:%h expected=%h:%h",
                 mem_addr, mem_data_write, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] s, input int i);
    if (s == 8'hD0) return 8'(i) ^ 8'hA5;
    if (c010_ab && i == 16) return 8'hAB;
    return 8'(i) ^ 8'h5A;
  endfunction

  task automatic push_xfer(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back({16'(DST + 16'(i)), exp_byte(s, i)});
    end
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    logic [7:0] e;
    cpu_addr     = addr;
    cpu_do_write = 1'b0;
    rd_q.push_back(exp);
    #3;
    e = rd_q.pop_front();
    chk(tag, 16'(cpu_data_read), 16'(e));
    tick();
  endtask

  task automatic cpu_write(input string tag, input logic [15:0] addr, input logic [7:0] data,
                           input logic exp_we);
    cpu_addr       = addr;
    cpu_data_write = data;
    cpu_do_write   = 1'b1;
    #3;
    chk(tag, 16'(mem_do_write), 16'(exp_we));
    tick();
    cpu_do_write = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (dma_active !== 1'b0 && k < 2000) begin
      tick();
      k++;
    end
    chk(tag, 16'(dma_active), 16'h0000);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    act_cnt        = 0;
    c010_ab        = 1'b0;
    reset          = 1'b1;
    cpu_addr       = 16'h0000;
    cpu_data_write = 8'h00;
    cpu_do_write   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
      mem[16'hFE00 + 16'(i)] = 8'hEE;
    end
    mem[16'h0100] = 8'h33;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state and idle pass-through
    chk("rst_active", 16'(dma_active), 16'h0000);
    cpu_read("rst_src", REG, 8'h00);
    cpu_read("idle_read", 16'hC005, 8'h05 ^ 8'h5A);

    // Full transfer from page C0 with CPU lockout checks
    a0 = act_cnt;
    push_xfer(8'hC0, LEN);
    cpu_write("reg_wr_no_strobe", REG, 8'hC0, 1'b0);
    chk("start_active", 16'(dma_active), 16'h0001);
    cpu_read("locked_read", 16'h0100, 8'hFF);
    cpu_write("locked_write_drop", 16'hC000, 8'h12, 1'b0);
    cpu_read("busy_src_read", REG, 8'hC0);
    wait_idle("xfer1_done");
    chk("xfer1_active_cycles", 16'(act_cnt - a0), 16'(1 + 2 * LEN));
    chk("xfer1_queue_empty", 16'(wr_q.size()), 16'h0000);
    chk("src_unchanged", 16'(mem[16'hC000]), 16'h005A);
    for (int i = 0; i < int'(LEN); i++)
      chk("xfer1_dst", 16'(mem[DST + 16'(i)]), 16'(8'(i) ^ 8'h5A));
    chk("dst_past_end", 16'(mem[DST + 16'(LEN)]), 16'h00EE);

    // Restart with page D0 while idx=50 is being read
    push_xfer(8'hC0, 50);
    cpu_write("restart_a", REG, 8'hC0, 1'b0);
    repeat (101) tick();
    push_xfer(8'hD0, LEN);
    cpu_write("restart_b", REG, 8'hD0, 1'b0);
    chk("restart_active", 16'(dma_active), 16'h0001);
    wait_idle("restart_done");
    chk("restart_queue_empty", 16'(wr_q.size()), 16'h0000);
    for (int i = 0; i < int'(LEN); i++)
      chk("restart_dst", 16'(mem[DST + 16'(i)]), 16'(8'(i) ^ 8'hA5));

    // Reset during READ of idx=10 beats a simultaneous start write
    push_xfer(8'hC0, 10);
    cpu_write("pre_reset_start", REG, 8'hC0, 1'b0);
    repeat (21) tick();
    reset          = 1'b1;
    cpu_addr       = REG;
    cpu_data_write = 8'hE0;
    cpu_do_write   = 1'b1;
    tick();
    reset        = 1'b0;
    cpu_do_write = 1'b0;
    chk("reset_inactive", 16'(dma_active), 16'h0000);
    cpu_read("reset_src", REG, 8'h00);
    repeat (3) tick();
    chk("reset_stays_idle", 16'(dma_active), 16'h0000);
    chk("reset_queue_empty", 16'(wr_q.size()), 16'h0000);
    for (int i = 0; i < int'(LEN); i++)
      chk("reset_dst", 16'(mem[DST + 16'(i)]), 16'(i < 10 ? (8'(i) ^ 8'h5A) : (8'(i) ^ 8'hA5)));

    // Idle CPU write then readback
    wr_q.push_back({16'hC010, 8'hAB});
    cpu_write("idle_write", 16'hC010, 8'hAB, 1'b1);
    c010_ab = 1'b1;
    cpu_read("idle_readback", 16'hC010, 8'hAB);

    // Start write landing on the final WRITE cycle chains a new transfer
    a0 = act_cnt;
    push_xfer(8'hD0, LEN);
    cpu_write("chain_a", REG, 8'hD0, 1'b0);
    repeat (320) tick();
    push_xfer(8'hC0, LEN);
    cpu_write("final_write_strobe", REG, 8'hC0, 1'b1);
    chk("chain_active", 16'(dma_active), 16'h0001);
    wait_idle("chain_done");
    chk("chain_active_cycles", 16'(act_cnt - a0), 16'(2 * (1 + 2 * LEN)));
    chk("chain_queue_empty", 16'(wr_q.size()), 16'h0000);
    chk("chain_dst_first", 16'(mem[16'hFE00]), 16'h005A);
    chk("chain_dst_c010", 16'(mem[16'hFE10]), 16'h00AB);
    chk("chain_dst_last", 16'(mem[16'hFE9F]), 16'(8'h9F ^ 8'h5A));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 The block SHALL have parameter LEN, default 160, meaning the number of bytes per transfer (1..256).
REQ-002 The block SHALL have parameter DST_BASE, default 16'hFE00, meaning the destination base address.
REQ-003 The block SHALL have parameter REG_ADDR, default 16'hFF46, meaning the DMA start-register address.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_addr  input  16  CPU bus address.
REQ-007 cpu_data_write  input  8  CPU write data.
REQ-008 cpu_do_write  input  1  CPU write strobe.
REQ-009 cpu_data_read  output  8  read data returned to the CPU.
REQ-010 mem_addr  output  16  address to the shared memory.
REQ-011 mem_data_write  output  8  write data to the memory.
REQ-012 mem_do_write  output  1  memory write strobe.
REQ-013 mem_data_read  input  8  combinational read data from the memory at mem_addr.
REQ-014 dma_active  output  1  high while the memory port is owned by DMA.

Function
REQ-015 The FSM SHALL have states IDLE, START, READ and WRITE; dma_active SHALL be 1 in every state except IDLE.
REQ-016 Arbitration SHALL be a fixed rule: IDLE gives the port to the CPU; START, READ and WRITE give the port to DMA; no CPU access ever reaches memory while dma_active=1.
REQ-017 In IDLE, mem_addr SHALL equal cpu_addr and mem_data_write SHALL equal cpu_data_write; mem_do_write SHALL equal cpu_do_write except when cpu_addr=REG_ADDR (then 0); cpu_data_read SHALL equal mem_data_read except when cpu_addr=REG_ADDR.
REQ-018 A read of REG_ADDR SHALL return the 8-bit src register in any state.
REQ-019 While dma_active=1, CPU reads of any address other than REG_ADDR SHALL return 8'hFF, and CPU writes other than to REG_ADDR SHALL be dropped.
REQ-020 A CPU write to REG_ADDR in any state SHALL load src with cpu_data_write, clear idx to 0 and enter START on the next edge; an in-progress transfer SHALL be abandoned (restart).
REQ-021 START SHALL last exactly one cycle, with mem_do_write=0, and then go to READ.
REQ-022 READ SHALL drive mem_addr={src,idx[7:0]} with mem_do_write=0, capture mem_data_read into an 8-bit buffer at the edge, and go to WRITE.
REQ-023 WRITE SHALL drive mem_addr=DST_BASE+idx (16-bit, wrapping), mem_data_write=buffer and mem_do_write=1.
REQ-024 From WRITE, if idx=LEN-1 the FSM SHALL go to IDLE, otherwise it SHALL increment idx and go to READ.
REQ-025 Latency SHALL be: register write at edge N gives START in cycle N+1, the first READ in N+2, and the last WRITE in N+1+2*LEN; dma_active SHALL be high for exactly 1+2*LEN cycles.
REQ-026 Simultaneous case: a REG_ADDR write during the final WRITE cycle SHALL still commit that final memory write, then go to START, not IDLE.
REQ-027 The source address SHALL be used without remapping; {src,idx} is 16 bits and idx SHALL never exceed LEN-1.
REQ-028 The block SHALL contain no combinational path from cpu_* inputs to mem_* outputs while dma_active=1.

Reset
REQ-029 On reset the block SHALL set state to IDLE, idx to 0, src to 8'h00 and buffer to 8'h00; dma_active SHALL be 0 in the following cycle.
REQ-030 Reset asserted mid-transfer SHALL cause no further DMA write, starting with the cycle after the reset edge, and SHALL return port ownership to the CPU.
REQ-031 Reset SHALL take priority over a simultaneous REG_ADDR write, which SHALL be discarded.

Verification
REQ-032 The bench SHALL cover: memory 0xC000..0xC09F preloaded with i^8'h5A, CPU writes 8'hC0 to FF46 -> FE00+i holds i^8'h5A for i=0..159, and dma_active is high for exactly 321 cycles.
REQ-033 The bench SHALL cover: during DMA, CPU reads 0x0100 -> returns 8'hFF; CPU writes 8'h12 to 0xC000 -> memory unchanged; CPU reads FF46 -> returns 8'hC0.
REQ-034 The bench SHALL cover: at idx=50, CPU writes 8'hD0 to FF46 -> restart, final FE00..FE9F equals source bytes from 0xD000.., and FE00..FE31 are overwritten.
REQ-035 The bench SHALL cover: reset asserted at idx=10 -> FE0A and above are unmodified, dma_active=0 one cycle later, and FF46 reads 8'h00.
REQ-036 The bench SHALL cover: in IDLE, CPU write of 8'hAB to 0xC010 then a read -> returns 8'hAB; a write to FF46 never produces mem_do_write=1 at address FF46.
REQ-037 The bench SHALL cover: FF46 write during the final WRITE cycle -> FE9F is written, then START follows with dma_active staying high continuously.
